// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the MEM stage. Storage is a byte-wide array, so a
// word access is four sequential byte beats; busy holds the pipeline until the
// one-cycle done pulse. Word data is big-endian (lowest address in [31:24]).
module data_mem_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        datamem_en,
  input  logic        rw,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  state_t            state_nxt;

  logic [7:0]        Mem [0:DEPTH-1];

  // Request latched on acceptance in IDLE; inputs are ignored afterwards.
  logic [ADDR_W-1:0] addr_p0;
  logic              rw_p0;
  logic              size_p0;
  logic [31:0]       wdata_p0;

  logic [1:0]        beat;
  logic [23:0]       acc;
  logic              err_q;

  logic              misaligned;
  logic              last_beat;
  logic              mem_we;
  logic [ADDR_W-1:0] byte_idx;
  logic [7:0]        rd_byte;
  logic [7:0]        wr_byte;

  // Address bits above ADDR_W are ignored, so the array wraps.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W];

  // Byte of the store data that belongs to a given beat.
  function automatic logic [7:0] store_byte(input logic [31:0] w,
                                            input logic        word,
                                            input logic [1:0]  b);
    logic [7:0] r;
    if (!word) begin
      r = w[7:0];
    end else begin
      case (b)
        2'd0:    r = w[31:24];
        2'd1:    r = w[23:16];
        2'd2:    r = w[15:8];
        default: r = w[7:0];
      endcase
    end
    return r;
  endfunction

  assign misaligned = size & (addr[1:0] != 2'b00);
  assign last_beat  = size_p0 ? (beat == 2'd3) : 1'b1;
  assign byte_idx   = addr_p0 + ADDR_W'(beat);
  assign rd_byte    = Mem[byte_idx];
  assign wr_byte    = store_byte(wdata_p0, size_p0, beat);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, handshake outputs and array write enable.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    err       = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (datamem_en) state_nxt = misaligned ? DONE : ACCESS;
      end
      ACCESS: begin
        mem_we = rw_p0;
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy = datamem_en & ~done & ~reset;
  end

  // Beat counter, error flag and load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat  <= 2'd0;
      err_q <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (datamem_en) begin
            beat  <= 2'd0;
            err_q <= misaligned;
            if (misaligned) rdata <= '0;
          end
        end
        ACCESS: begin
          beat <= last_beat ? 2'd0 : beat + 2'd1;
          if (last_beat) rdata <= rw_p0 ? 32'h0 : {acc, rd_byte};
        end
        DONE:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Request capture and read accumulator (data path, not reset).
  always_ff @(posedge clk) begin
    if (state == IDLE && datamem_en) begin
      addr_p0  <= addr[ADDR_W-1:0];
      rw_p0    <= rw;
      size_p0  <= size;
      wdata_p0 <= wdata;
      acc      <= '0;
    end else if (state == ACCESS) begin
      acc <= {acc[15:0], rd_byte};
    end
  end

  // Byte array write port; never cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) Mem[byte_idx] <= wr_byte;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: transaction-level reference model plus directed
// literal cases and randomized requests with inputs disturbed mid-access.
module tb_data_mem_ctrl;

  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        datamem_en = 1'b0;
  logic        rw         = 1'b0;
  logic        size       = 1'b0;
  logic [31:0] addr       = '0;
  logic [31:0] wdata      = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .datamem_en(datamem_en),
    .rw        (rw),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Expected completion of one accepted request.
  typedef struct {
    int          when;
    logic [31:0] rd;
    logic        er;
    logic        wr;
    logic        sz;
    int          a;
    logic [31:0] wd;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mm [0:DEPTH-1];
  int          cyc     = 0;
  int          free_at = 0;
  exp_t        e;
  logic        exp_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  task automatic put(input int idx, input logic [7:0] v);
    dut.Mem[idx] = v;
    mm[idx]      = v;
  endtask

  // Reference model and per-cycle compare: a request is taken when the
  // responder is free, completes after 1/2/5 cycles, writes land by done.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_err",  32'(err),  32'd0);
      q.delete();
      free_at = 0;
    end else begin
      exp_done = (q.size() > 0) && (q[0].when == cyc);
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(datamem_en & ~exp_done));
      if (exp_done) begin
        e = q.pop_front();
        chk("rdata", rdata, e.rd);
        chk("err", 32'(err), 32'(e.er));
        if (e.wr) begin
          if (e.sz) begin
            for (int k = 0; k < 4; k++) mm[(e.a + k) % DEPTH] = e.wd[31 - 8*k -: 8];
          end else begin
            mm[e.a] = e.wd[7:0];
          end
        end
      end else begin
        chk("err_idle", 32'(err), 32'd0);
      end
      if (datamem_en && cyc >= free_at) begin
        e.a  = int'(addr[AW-1:0]);
        e.sz = size;
        e.wd = wdata;
        e.wr = 1'b0;
        e.er = 1'b0;
        e.rd = '0;
        if (size && addr[1:0] != 2'b00) begin
          e.er   = 1'b1;
          e.when = cyc + 1;
        end else begin
          e.when = cyc + (size ? 5 : 2);
          if (rw) e.wr = 1'b1;
          else if (size) e.rd = {mm[e.a], mm[(e.a+1) % DEPTH], mm[(e.a+2) % DEPTH], mm[(e.a+3) % DEPTH]};
          else e.rd = {24'h0, mm[e.a]};
        end
        q.push_back(e);
        free_at = e.when + 1;
      end
    end
  end

  // One request: held until done (bounded), optionally scrambling inputs.
  task automatic txn(input logic r, input logic s, input logic [31:0] a, input logic [31:0] w,
                     input bit scramble, output int lat, output logic [31:0] rd, output logic er);
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    @(posedge clk); #1;
    datamem_en = 1'b1; rw = r; size = s; addr = a; wdata = w;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk); #1;
      if (done) begin
        lat = n; rd = rdata; er = err;
        break;
      end
      @(posedge clk); #1;
      if (scramble) begin
        datamem_en = 1'($urandom); rw = 1'($urandom); size = 1'($urandom);
        addr = $urandom; wdata = $urandom;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL txn_timeout cycle=%0d actual=no_done required=done", cyc);
    end
    @(posedge clk); #1;
    datamem_en = 1'b0;
  endtask

  int          lat, d1, d2;
  logic [31:0] rd, rd1, rd2, ra;
  logic        er;

  initial begin
    for (int i = 0; i < DEPTH; i++) put(i, 8'($urandom));
    put(0, 8'hE2); put(1, 8'h11); put(2, 8'h00); put(3, 8'h00);
    put(4, 8'h44); put(5, 8'h55); put(6, 8'h66);
    for (int i = 12; i < 16; i++) put(i, 8'h00);

    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post_reset_rdata", rdata, 32'h0);
    chk("post_reset_done", 32'(done), 32'd0);

    // Word read of preloaded data
    txn(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, lat, rd, er);
    chk("t1_lat", 32'(lat), 32'd5);
    chk("t1_rdata", rd, 32'hE2110000);
    chk("t1_err", 32'(er), 32'd0);

    // Byte store then byte read
    txn(1'b1, 1'b0, 32'h05, 32'h000000A5, 1'b0, lat, rd, er);
    chk("t2_wr_lat", 32'(lat), 32'd2);
    chk("t2_mem5", 32'(dut.Mem[5]), 32'hA5);
    chk("t2_mem4", 32'(dut.Mem[4]), 32'h44);
    chk("t2_mem6", 32'(dut.Mem[6]), 32'h66);
    txn(1'b0, 1'b0, 32'h05, 32'h0, 1'b1, lat, rd, er);
    chk("t2_rd_lat", 32'(lat), 32'd2);
    chk("t2_rdata", rd, 32'h000000A5);

    // Word store then word read
    txn(1'b1, 1'b1, 32'd16, 32'hDEADBEEF, 1'b1, lat, rd, er);
    chk("t3_wr_lat", 32'(lat), 32'd5);
    chk("t3_mem", {dut.Mem[16], dut.Mem[17], dut.Mem[18], dut.Mem[19]}, 32'hDEADBEEF);
    txn(1'b0, 1'b1, 32'd16, 32'h0, 1'b0, lat, rd, er);
    chk("t3_rdata", rd, 32'hDEADBEEF);

    // Misaligned word read
    txn(1'b0, 1'b1, 32'd2, 32'h0, 1'b0, lat, rd, er);
    chk("t4_lat", 32'(lat), 32'd1);
    chk("t4_err", 32'(er), 32'd1);
    chk("t4_rdata", rd, 32'h0);
    chk("t4_mem", {dut.Mem[0], dut.Mem[1], dut.Mem[2], dut.Mem[3]}, 32'hE2110000);

    // Word store interrupted by reset after beat 1
    @(posedge clk); #1;
    datamem_en = 1'b1; rw = 1'b1; size = 1'b1; addr = 32'd12; wdata = 32'h12345678;
    repeat (3) @(posedge clk); #1;
    reset = 1'b1; datamem_en = 1'b0;
    @(negedge clk); #1;
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_mem", {dut.Mem[12], dut.Mem[13], dut.Mem[14], dut.Mem[15]}, 32'h12340000);
    mm[12] = 8'h12; mm[13] = 8'h34;
    txn(1'b0, 1'b1, 32'd12, 32'h0, 1'b0, lat, rd, er);
    chk("t5_readback", rd, 32'h12340000);

    // Wrapped byte read with datamem_en held through two requests
    @(posedge clk); #1;
    datamem_en = 1'b1; rw = 1'b0; size = 1'b0; addr = 32'h0000_0201; wdata = '0;
    d1 = -1; d2 = -1; rd1 = '0; rd2 = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (done) begin
        if (d1 < 0) begin d1 = n; rd1 = rdata; end
        else begin d2 = n; rd2 = rdata; break; end
      end
    end
    @(posedge clk); #1;
    datamem_en = 1'b0;
    chk("t6_first_done", 32'(d1), 32'd2);
    chk("t6_second_done", 32'(d2), 32'd5);
    chk("t6_rdata1", rd1, 32'h00000011);
    chk("t6_rdata2", rd2, 32'h00000011);

    // Randomized requests
    for (int i = 0; i < 80; i++) begin
      ra = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 47));
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      txn(1'($urandom), 1'($urandom), ra, $urandom, 1'($urandom), lat, rd, er);
    end

    repeat (3) @(posedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
